// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: pipeline controls and program-load port in, registered fetch results out.
interface fetch_unit_if #(
    parameter int DATA_W = 32
);
    logic              freeze;
    logic              br_taken;
    logic [DATA_W-1:0] br_addr;
    logic              flush;
    logic              ld_we;
    logic [DATA_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] instr_out;
    logic              valid_out;

    modport master (
        output freeze, br_taken, br_addr, flush, ld_we, ld_addr, ld_data,
        input  pc_out, instr_out, valid_out
    );

    modport slave (
        input  freeze, br_taken, br_addr, flush, ld_we, ld_addr, ld_data,
        output pc_out, instr_out, valid_out
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, word-addressed instruction memory with
// combinational read, and a one-deep output register with stall/flush/redirect.
module fetch_unit #(
    parameter int              DATA_W    = 32,
    parameter int              MEM_DEPTH = 1024,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    fetch_unit_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [DATA_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] pc_out_reg, pc_out_next;
    logic [DATA_W-1:0] instr_out_reg, instr_out_next;
    logic              valid_out_reg, valid_out_next;

    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     wr_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] pc_inc;

    // Byte offset and bits above the memory size are dropped, so fetches wrap.
    assign rd_idx  = AW'(pc_reg >> 2);
    assign wr_idx  = AW'(bus.ld_addr >> 2);
    assign rd_word = mem[rd_idx];
    assign pc_inc  = pc_reg + DATA_W'(PC_STEP);

    // Program load is independent of rst; the read above sees the old word this cycle.
    always_ff @(posedge clk) begin
        if (bus.ld_we) begin
            mem[wr_idx] <= bus.ld_data;
        end
    end

    always_comb begin
        pc_next = pc_reg;
        if (bus.br_taken) begin
            pc_next = bus.br_addr;
        end else if (!bus.freeze) begin
            pc_next = pc_inc;
        end
    end

    // Flush kills only the output slot; a concurrent freeze still holds pc.
    always_comb begin
        pc_out_next    = pc_out_reg;
        instr_out_next = instr_out_reg;
        valid_out_next = valid_out_reg;
        if (bus.flush || bus.br_taken) begin
            pc_out_next    = '0;
            instr_out_next = '0;
            valid_out_next = 1'b0;
        end else if (!bus.freeze) begin
            pc_out_next    = pc_inc;
            instr_out_next = rd_word;
            valid_out_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            pc_out_reg    <= '0;
            instr_out_reg <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            pc_out_reg    <= pc_out_next;
            instr_out_reg <= instr_out_next;
            valid_out_reg <= valid_out_next;
        end
    end

    assign bus.pc_out    = pc_out_reg;
    assign bus.instr_out = instr_out_reg;
    assign bus.valid_out = valid_out_reg;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters, one per line (name, default, meaning): the block SHALL provide exactly the following.
  DATA_W, 32, width of the PC, the branch address and the instruction word.
  MEM_DEPTH, 1024, number of instruction words; power of two, minimum 4.
  RESET_PC, 0, PC value loaded on reset; word-aligned.
  PC_STEP, 4, byte increment applied per sequential fetch.
REQ-002 Ports, one per line (name, direction, width, meaning): the block SHALL provide exactly the following.
  clk, in, 1, single clock; all state updates on its rising edge.
  rst, in, 1, synchronous reset, active-high.
  freeze, in, 1, stall request; holds the PC and the output register.
  br_taken, in, 1, redirect request from a later stage.
  br_addr, in, DATA_W, redirect target byte address.
  flush, in, 1, kill the instruction being registered this cycle.
  ld_we, in, 1, instruction-memory write enable for program load.
  ld_addr, in, DATA_W, program-load byte address.
  ld_data, in, DATA_W, program-load word.
  pc_out, out, DATA_W, registered PC+PC_STEP of the fetched instruction.
  instr_out, out, DATA_W, registered fetched instruction.
  valid_out, out, 1, instr_out holds a live instruction.

Function
REQ-003 Internal register pc SHALL hold the current fetch byte address.
REQ-004 Memory index SHALL be pc[log2(MEM_DEPTH)+1:2]; upper bits and bits [1:0] are ignored, so addresses wrap modulo MEM_DEPTH words.
REQ-005 Memory read SHALL be combinational from pc; memory write SHALL occur on the clk edge when ld_we=1, at index ld_addr[log2(MEM_DEPTH)+1:2].
REQ-006 On read-during-write to the same index, the fetch SHALL return the old word; the new word is visible from the next cycle.
REQ-007 Memory SHALL power up all-zero; rst SHALL NOT clear memory.
REQ-008 pc update priority SHALL be: rst -> RESET_PC; else br_taken -> br_addr; else freeze -> hold; else pc+PC_STEP, truncated to DATA_W bits (wrap from all-ones to low values).
REQ-009 br_taken SHALL override freeze for the pc update.
REQ-010 Output register priority SHALL be: rst -> all zero; else flush or br_taken -> pc_out=0, instr_out=0 (NOP), valid_out=0; else freeze -> hold all three; else pc_out=pc+PC_STEP, instr_out=mem[index(pc)], valid_out=1.
REQ-011 Latency SHALL be one cycle: the word at pc appears on instr_out after the next rising edge on which the fetch is not frozen, flushed or redirected.
REQ-012 The first instruction fetched after a redirect SHALL be mem[index(br_addr)], registered one edge after the br_taken edge; zero bubbles beyond the killed slot.
REQ-013 When flush and freeze are both high, flush SHALL win for the output register and freeze SHALL still hold pc.
REQ-014 A misaligned br_addr SHALL be stored verbatim in pc; indexing still ignores bits [1:0].

Reset
REQ-015 When rst=1 at a rising edge, pc SHALL become RESET_PC and pc_out, instr_out and valid_out SHALL become 0, regardless of every other input, including mid-stall or mid-redirect.
REQ-016 On the first edge after rst deasserts with other controls low, outputs SHALL be pc_out=RESET_PC+PC_STEP, instr_out=mem[index(RESET_PC)] and valid_out=1.
REQ-017 ld_we asserted together with rst SHALL still write memory.

Verification
REQ-018 Load 0x11,0x22,0x33 at byte addresses 0,4,8, then reset and run 3 cycles -> instr_out 0x11/0x22/0x33, pc_out 4/8/12, valid_out 1.
REQ-019 Assert freeze for 2 cycles while instr_out=0x22 -> instr_out stays 0x22 and pc_out stays 8 for 2 cycles; the next edge gives 0x33.
REQ-020 Assert br_taken with br_addr=0 while fetching at 8 -> the next edge gives instr_out=0, valid_out=0; the following edge gives instr_out=0x11, pc_out=4.
REQ-021 Assert flush and freeze together -> valid_out=0, instr_out=0; pc unchanged, so the next fetch repeats the same address.
REQ-022 With MEM_DEPTH=16 and word 0 = 0xAA, fetch at byte address 60 then 64 -> the second instr_out=0xAA with pc_out=68. With RESET_PC=0xFFFFFFFC -> the PC wraps to 0 and the second pc_out=4.
REQ-023 Assert rst while freeze=1 and br_taken=1 -> all outputs 0; the next edge after release gives pc_out=RESET_PC+4.
